// File: rtl/mem_port_arbiter.sv
// Shares the core memory bus between fetch (F) and the memory stage (D), routing in-order responses back by tag.
// Latency: zero added cycles; a grant is issued in the accept cycle and a response is routed in its bus_rvalid cycle.
// Backpressure: bus_req drops while MAX_OUTSTANDING transactions are unanswered or rst is high; bus_ready stalls grants.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   f_req/f_addr/f_gnt             fetch request (read only), held until f_gnt
//   f_flush                        drop every in-flight fetch response (taken jump)
//   f_rvalid/f_rdata               fetch response
//   d_req/d_we/d_addr/d_wdata/d_gnt  data request, held until d_gnt
//   d_rvalid/d_rdata               data response (load data or store completion)
//   bus_req/bus_we/bus_addr/bus_wdata/bus_ready  request side of the memory bus
//   bus_rvalid/bus_rdata           in-order response side of the memory bus
//   err                            sticky: response arrived with nothing outstanding
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    input  logic        f_flush,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    // Tag FIFO: one {is_fetch, drop} pair per accepted, unanswered transaction.
    logic [MAX_OUTSTANDING-1:0] tag_fetch;
    logic [MAX_OUTSTANDING-1:0] tag_drop;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           occupancy;
    logic [STV_W-1:0]           starve_cnt;

    logic full;
    logic empty;
    logic sel_f;
    logic accept;
    logic push;
    logic pop;
    logic head_fetch;
    logic head_drop;
    logic resp_ok;

    // Full is taken from the registered occupancy only: a pop in the same
    // cycle does not free a slot until the next cycle.
    assign full  = (occupancy == CNT_W'(MAX_OUTSTANDING));
    assign empty = (occupancy == '0);

    // D wins by default; F wins when D is idle or after STARVE_LIMIT
    // consecutive D grants taken while F was waiting.
    assign sel_f = ~d_req | ((starve_cnt == STV_W'(STARVE_LIMIT)) & f_req);

    assign bus_req   = (f_req | d_req) & ~full & ~rst;
    assign accept    = bus_req & bus_ready;
    assign f_gnt     = accept & sel_f;
    assign d_gnt     = accept & ~sel_f;
    assign bus_we    = sel_f ? 1'b0 : d_we;
    assign bus_addr  = sel_f ? f_addr : d_addr;
    assign bus_wdata = sel_f ? '0 : d_wdata;

    assign push = accept;
    assign pop  = bus_rvalid & ~empty;

    assign head_fetch = tag_fetch[rd_ptr];
    assign head_drop  = tag_drop[rd_ptr];

    // A response with nothing outstanding is never forwarded.
    assign resp_ok  = bus_rvalid & ~empty & ~rst;
    assign f_rvalid = resp_ok & head_fetch & ~head_drop & ~f_flush;
    assign d_rvalid = resp_ok & ~head_fetch;
    assign f_rdata  = bus_rdata;
    assign d_rdata  = bus_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            tag_fetch <= '0;
            tag_drop  <= '0;
        end else begin
            // Flush marks every queued fetch; the push below overrides its own
            // slot and already carries the flush in its drop bit.
            if (f_flush) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    if (tag_fetch[i]) begin
                        tag_drop[i] <= 1'b1;
                    end
                end
            end
            if (push) begin
                tag_fetch[wr_ptr] <= sel_f;
                tag_drop[wr_ptr]  <= sel_f & f_flush;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Counts D grants taken over a waiting F; any F grant or F going idle
    // restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (f_gnt || !f_req) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bus_rvalid && empty) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAXO = 4;
    localparam int SL   = 4;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_flush;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        err;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_flush(f_flush),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Outstanding transactions as a queue of requester tags, a plain integer
    // for the run of D grants over a waiting F, and the sticky error flag.
    typedef struct packed {
        logic is_fetch;
        logic drop;
    } tag_t;

    tag_t q[$];
    int   m_starve = 0;
    bit   m_err = 1'b0;

    always @(negedge clk) begin
        bit   full, breq, self, acc, ef, ed;
        tag_t h;
        tag_t t;
        if (rst) begin
            check("rst_bus_req", bus_req, 0);
            check("rst_f_gnt", f_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_f_rvalid", f_rvalid, 0);
            check("rst_d_rvalid", d_rvalid, 0);
            q.delete();
            m_starve = 0;
            m_err = 1'b0;
        end else begin
            full = (q.size() == MAXO);
            breq = (f_req || d_req) && !full;
            self = !d_req || (m_starve == SL && f_req);
            acc  = breq && bus_ready;
            check("m_bus_req", bus_req, breq);
            check("m_f_gnt", f_gnt, acc && self);
            check("m_d_gnt", d_gnt, acc && !self);
            if (breq) begin
                check("m_bus_addr", bus_addr, self ? f_addr : d_addr);
                check("m_bus_we", bus_we, self ? 1'b0 : d_we);
                if (!self && d_we) check("m_bus_wdata", bus_wdata, d_wdata);
            end
            ef = 1'b0;
            ed = 1'b0;
            if (bus_rvalid && q.size() > 0) begin
                h  = q[0];
                ef = h.is_fetch && !h.drop && !f_flush;
                ed = !h.is_fetch;
            end
            check("m_f_rvalid", f_rvalid, ef);
            check("m_d_rvalid", d_rvalid, ed);
            if (ef) check("m_f_rdata", f_rdata, bus_rdata);
            if (ed) check("m_d_rdata", d_rdata, bus_rdata);
            check("m_err", err, m_err);
            // advance to the state after this edge
            if (bus_rvalid) begin
                if (q.size() == 0) m_err = 1'b1;
                else void'(q.pop_front());
            end
            if (f_flush) begin
                foreach (q[i]) if (q[i].is_fetch) q[i].drop = 1'b1;
            end
            if (acc) begin
                t.is_fetch = self;
                t.drop     = self && f_flush;
                q.push_back(t);
            end
            if ((acc && self) || !f_req) m_starve = 0;
            else if (acc && !self && m_starve < SL) m_starve++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] gseq;
        int nf, nd;
        rst = 1'b1; f_req = 0; f_addr = 0; f_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        step; step;
        rst = 1'b0;

        // 1: single fetch, response two cycles after the accept
        f_req = 1; f_addr = 32'h100; bus_ready = 1;
        mid; check("t1_f_gnt", f_gnt, 1); check("t1_bus_addr", bus_addr, 32'h100);
        step;
        f_req = 0;
        mid; step;
        bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
        mid;
        check("t1_f_rvalid", f_rvalid, 1);
        check("t1_f_rdata", f_rdata, 32'hDEADBEEF);
        check("t1_d_rvalid", d_rvalid, 0);
        step;
        bus_rvalid = 0;

        // 2: both requesting for 10 cycles, response one cycle after each accept
        f_req = 1; d_req = 1; d_we = 0; f_addr = 32'h200; d_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            bus_rvalid = (i > 0);
            bus_rdata  = 32'h1000 + i;
            mid;
            gseq[i] = f_gnt;
            step;
        end
        f_req = 0; d_req = 0; bus_rvalid = 1; bus_rdata = 32'h100A;
        mid; step;
        bus_rvalid = 0;
        check("t2_grant_seq", {22'd0, gseq}, {22'd0, 10'b1000010000});

        // 3: fill to MAX_OUTSTANDING with stores, then pop while full
        d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h55;
        for (int i = 0; i < 4; i++) begin
            mid; check("t3_d_gnt", d_gnt, 1); step;
        end
        bus_rvalid = 1; bus_rdata = 32'h0;
        mid; check("t3_full_bus_req", bus_req, 0); check("t3_pop_d_rvalid", d_rvalid, 1);
        step;
        bus_rvalid = 0;
        mid; check("t3_reopen_bus_req", bus_req, 1); check("t3_reopen_d_gnt", d_gnt, 1);
        step;
        d_req = 0; d_we = 0; bus_rvalid = 1;
        for (int i = 0; i < 4; i++) begin
            mid; check("t3_drain_d_rvalid", d_rvalid, 1); step;
        end
        bus_rvalid = 0;

        // 4: F,D,F outstanding, flush, then three responses
        f_req = 1; f_addr = 32'h500;
        mid; check("t4_f_gnt0", f_gnt, 1); step;
        f_req = 0; d_req = 1; d_addr = 32'h600;
        mid; check("t4_d_gnt", d_gnt, 1); step;
        d_req = 0; f_req = 1; f_addr = 32'h504;
        mid; check("t4_f_gnt1", f_gnt, 1); step;
        f_req = 0; f_flush = 1;
        mid; step;
        f_flush = 0;
        nf = 0; nd = 0;
        for (int i = 0; i < 3; i++) begin
            bus_rvalid = 1; bus_rdata = 32'h700 + i;
            mid;
            nf += int'(f_rvalid);
            nd += int'(d_rvalid);
            check("t4_d_rvalid_slot", d_rvalid, (i == 1));
            step;
        end
        bus_rvalid = 0;
        check("t4_f_rvalid_count", nf, 0);
        check("t4_d_rvalid_count", nd, 1);

        // 5: flush coinciding with an F accept and a fetch response at head
        f_req = 1; f_addr = 32'h800;
        mid; step;
        f_addr = 32'h900; f_flush = 1; bus_rvalid = 1; bus_rdata = 32'h11;
        mid; check("t5_flush_f_gnt", f_gnt, 1); check("t5_flush_head", f_rvalid, 0);
        step;
        f_flush = 0; f_addr = 32'hA00; bus_rdata = 32'h22;
        mid; check("t5_next_f_gnt", f_gnt, 1); check("t5_dropped_push", f_rvalid, 0);
        step;
        f_req = 0; bus_rdata = 32'h33;
        mid; check("t5_after_flush", f_rvalid, 1); check("t5_after_rdata", f_rdata, 32'h33);
        step;
        bus_rvalid = 0;

        // 6: reset with two outstanding, then late responses
        d_req = 1; d_addr = 32'hB00;
        mid; step;
        d_addr = 32'hB04;
        mid; step;
        d_req = 0; rst = 1;
        mid; step;
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            bus_rvalid = 1; bus_rdata = 32'hBAD;
            mid;
            check("t6_late_f_rvalid", f_rvalid, 0);
            check("t6_late_d_rvalid", d_rvalid, 0);
            step;
        end
        bus_rvalid = 0;
        mid; check("t6_err_set", err, 1); step;
        step; step; step;
        mid; check("t6_err_sticky", err, 1); step;
        rst = 1;
        step;
        rst = 0;
        mid; check("t6_err_cleared", err, 0); step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory bus between instruction fetch (requester F) and the memory stage (requester D).
- Issues requests in order and tags each accepted transaction with its requester in a small tag FIFO, so in-order responses route back to the correct requester.
- Supports a fetch flush: when decode raises discard on a taken jump, every in-flight fetch response is dropped.
- Prevents fetch starvation during long load/store runs.

Parameters:
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered bus transactions (tag FIFO depth, power of two, >=2)
STARVE_LIMIT, 4, consecutive D grants while F is waiting before F gets forced priority for one grant

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
f_req  in  1  fetch request; held with f_addr until f_gnt
f_addr  in  32  fetch address
f_gnt  out  1  fetch request accepted this cycle
f_flush  in  1  drop all outstanding fetch responses (jump taken)
f_rvalid  out  1  fetch response valid
f_rdata  out  32  fetch response data
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  data request is a write
d_addr  in  32  data address
d_wdata  in  32  write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data response valid (load data or store completion)
d_rdata  out  32  data response data (undefined for stores)
bus_req  out  1  request to memory bus
bus_we  out  1  bus write
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_ready  in  1  bus accepts request this cycle (accept = bus_req & bus_ready)
bus_rvalid  in  1  bus response, exactly one per accepted request, in order
bus_rdata  in  32  bus response data
err  out  1  sticky: bus_rvalid arrived with tag FIFO empty

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high. Reset empties the tag FIFO, zeroes the starvation counter and clears err.
  - Combinational outputs follow from the empty state: f_gnt, d_gnt, f_rvalid, d_rvalid and bus_req are 0 while rst is high.
  - A bus response arriving after a reset with the FIFO empty is discarded and sets err; it is not forwarded.
- Full condition: full = (occupancy == MAX_OUTSTANDING).
  - No accept occurs while full, even if a pop happens in the same cycle. The occupancy is registered; the condition is not bypassed.
- Request: bus_req = (f_req | d_req) & ~full & ~rst.
- Selection (combinational):
  - D is the default winner when d_req is high.
  - F wins when d_req is low, or when starve_cnt == STARVE_LIMIT and f_req is high.
  - bus_we/bus_addr/bus_wdata are taken from the winner; F is always a read.
- Grants: f_gnt = accept & F selected; d_gnt = accept & D selected. Zero-cycle grant; the requester may change its inputs in the next cycle.
- Starvation counter:
  - Increments on a D accept while f_req is high, saturating at STARVE_LIMIT.
  - Clears on an F accept or when f_req is low.
- Tag FIFO:
  - Each entry holds {is_fetch, drop}.
  - Push on accept: is_fetch is the selection, drop = is_fetch & f_flush.
  - Pop on bus_rvalid with a non-empty FIFO.
  - Simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Response routing (combinational, same cycle as bus_rvalid):
  - f_rvalid = bus_rvalid & head.is_fetch & ~head.drop & ~f_flush.
  - d_rvalid = bus_rvalid & ~head.is_fetch.
  - f_rdata = d_rdata = bus_rdata.
- Flush: in the cycle f_flush is high:
  - every queued fetch entry gets drop set, at the next edge;
  - a fetch pushed in that cycle is pushed with drop set;
  - a fetch response at the head in that cycle is suppressed.
  - Data entries are never dropped. f_flush does not block new grants; the fetch unit re-requests the target.
- Latency: one bus_rvalid edge maps to a requester response in the same cycle. The arbiter adds no cycles on the request or response path.

Test Plan:
- Reset, then f_req only at addr 0x100 with bus_ready=1 and response 2 cycles later with rdata 0xDEADBEEF -> f_gnt same cycle, bus_addr=0x100, f_rvalid=1 with f_rdata=0xDEADBEEF, d_rvalid=0.
- f_req and d_req held for 10 cycles, bus_ready=1, STARVE_LIMIT=4 -> grant sequence D,D,D,D,F,D,D,D,D,F; responses routed in issue order.
- bus_ready=1 with no responses for 4 cycles, MAX_OUTSTANDING=4 -> 4 accepts, then bus_req=0. One bus_rvalid -> bus_req stays 0 that cycle and re-asserts the next cycle.
- Issue F,D,F (3 outstanding), pulse f_flush before any response, return 3 responses -> f_rvalid never asserts; d_rvalid asserts exactly once, on the 2nd response.
- f_flush asserted in the same cycle as an F accept and as a fetch response at the head -> both suppressed; the next F accepted after the flush returns f_rvalid normally.
- 2 outstanding, rst for 1 cycle, then 2 late bus_rvalid pulses -> no f_rvalid/d_rvalid, err=1 and stays 1 until the next rst.
